// File: rtl/add_sub_pkg.sv
// Shared constants for the registered adder/subtractor slice.
//   MODE_ADD / MODE_SUB : encodings of the mode select input m.
//   ADD_SUB_WIDTH       : default operand/result width.
package add_sub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int unsigned ADD_SUB_WIDTH = 4;

endpackage

// File: rtl/four_bit_adder_subtractor_if.sv
// Operand/result bundle for four_bit_adder_subtractor.
//   A, B     : operands (driven by master)
//   m        : mode select, 0 = add, 1 = subtract (driven by master)
//   Sum      : registered result, low WIDTH bits (driven by slave)
//   Carry    : registered carry-out of the MSB stage (driven by slave)
//   Overflow : registered signed overflow, only when ADD_SUB_OVERFLOW_EN is defined
interface four_bit_adder_subtractor_if
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_SUB_WIDTH
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             m;
    logic [WIDTH-1:0] Sum;
    logic             Carry;

`ifdef ADD_SUB_OVERFLOW_EN
    logic             Overflow;

    modport master (output A, output B, output m, input Sum, input Carry, input Overflow);
    modport slave  (input A, input B, input m, output Sum, output Carry, output Overflow);
`else
    modport master (output A, output B, output m, input Sum, input Carry);
    modport slave  (input A, input B, input m, output Sum, output Carry);
`endif

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder, purely combinational.
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/four_bit_adder_subtractor.sv
// Registered WIDTH-bit two's-complement adder/subtractor.
// m = 0 computes A + B, m = 1 computes A + ~B + 1 on the same ripple chain.
// Results are captured on the rising clock edge (1-cycle latency, no enable).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all outputs
//   bus   : slave side of four_bit_adder_subtractor_if (A, B, m in; Sum, Carry out)
// Optional: define ADD_SUB_OVERFLOW_EN to add a registered signed Overflow output.
module four_bit_adder_subtractor
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_SUB_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    four_bit_adder_subtractor_if.slave   bus
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Subtract reuses the adder: invert B and inject the +1 through carry-in.
    assign b_eff    = bus.B ^ {WIDTH{bus.m}};
    assign carry[0] = (bus.m == MODE_SUB);

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (bus.A[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (sum_d[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry[WIDTH];
        end
    end

    assign bus.Sum   = sum_q;
    assign bus.Carry = carry_q;

`ifdef ADD_SUB_OVERFLOW_EN
    logic overflow_q;

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign bus.Overflow = overflow_q;
`endif

endmodule

// File: tb/tb_four_bit_adder_subtractor.sv
// Self-checking bench for four_bit_adder_subtractor (WIDTH = 4).
module tb_four_bit_adder_subtractor;

    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    four_bit_adder_subtractor_if #(.WIDTH(W)) dut_if ();

    four_bit_adder_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set operands on the falling edge, let one rising edge capture them,
    // then return 1 time unit later for sampling.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic md);
        @(negedge clk);
        dut_if.A = a;
        dut_if.B = b;
        dut_if.m = md;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        dut_if.A = 4'b1101;
        dut_if.B = 4'b0011;
        dut_if.m = 1'b0;
        #1;
        checks++;
        if (dut_if.Sum !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sum_immediate: got %b expected 0000", dut_if.Sum);
        end
        checks++;
        if (dut_if.Carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry_immediate: got %b expected 0", dut_if.Carry);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_if.Sum !== 4'b0000 || dut_if.Carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got sum %b carry %b expected 0000/0",
                     dut_if.Sum, dut_if.Carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (dut_if.Sum !== 4'b0000 || dut_if.Carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_no_capture: got sum %b carry %b expected 0000/0",
                     dut_if.Sum, dut_if.Carry);
        end
    endtask

    task automatic test_add();
        drive(4'b1101, 4'b0011, 1'b0);
        checks++;
        if (dut_if.Sum !== 4'b0000) begin
            errors++;
            $display("FAIL add_13_3_sum: got %b expected 0000", dut_if.Sum);
        end
        checks++;
        if (dut_if.Carry !== 1'b1) begin
            errors++;
            $display("FAIL add_13_3_carry: got %b expected 1", dut_if.Carry);
        end
        drive(4'b1111, 4'b0001, 1'b0);
        checks++;
        if (dut_if.Sum !== 4'b0000 || dut_if.Carry !== 1'b1) begin
            errors++;
            $display("FAIL add_15_1_wrap: got sum %b carry %b expected 0000/1",
                     dut_if.Sum, dut_if.Carry);
        end
        drive(4'b0010, 4'b0101, 1'b0);
        checks++;
        if (dut_if.Sum !== 4'b0111 || dut_if.Carry !== 1'b0) begin
            errors++;
            $display("FAIL add_2_5: got sum %b carry %b expected 0111/0",
                     dut_if.Sum, dut_if.Carry);
        end
    endtask

    task automatic test_sub_no_borrow();
        drive(4'b1111, 4'b0011, 1'b1);
        checks++;
        if (dut_if.Sum !== 4'b1100 || dut_if.Carry !== 1'b1) begin
            errors++;
            $display("FAIL sub_15_3: got sum %b carry %b expected 1100/1",
                     dut_if.Sum, dut_if.Carry);
        end
        drive(4'b1001, 4'b0011, 1'b1);
        checks++;
        if (dut_if.Sum !== 4'b0110 || dut_if.Carry !== 1'b1) begin
            errors++;
            $display("FAIL sub_9_3: got sum %b carry %b expected 0110/1",
                     dut_if.Sum, dut_if.Carry);
        end
    endtask

    task automatic test_sub_borrow();
        drive(4'b0000, 4'b0001, 1'b1);
        checks++;
        if (dut_if.Sum !== 4'b1111 || dut_if.Carry !== 1'b0) begin
            errors++;
            $display("FAIL sub_0_1_borrow: got sum %b carry %b expected 1111/0",
                     dut_if.Sum, dut_if.Carry);
        end
        drive(4'b0101, 4'b0101, 1'b1);
        checks++;
        if (dut_if.Sum !== 4'b0000 || dut_if.Carry !== 1'b1) begin
            errors++;
            $display("FAIL sub_5_5_equal: got sum %b carry %b expected 0000/1",
                     dut_if.Sum, dut_if.Carry);
        end
        drive(4'b0011, 4'b1000, 1'b1);
        checks++;
        if (dut_if.Sum !== 4'b1011 || dut_if.Carry !== 1'b0) begin
            errors++;
            $display("FAIL sub_3_8_borrow: got sum %b carry %b expected 1011/0",
                     dut_if.Sum, dut_if.Carry);
        end
    endtask

    // Alternating modes every cycle; each result must appear after exactly one edge
    // and be held unchanged until the following edge.
    task automatic test_back_to_back();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vm [6];
        logic [W-1:0] es [6];
        logic         ec [6];
        va = '{4'd7, 4'd7, 4'd12, 4'd2, 4'd9, 4'd1};
        vb = '{4'd4, 4'd4, 4'd5,  4'd6, 4'd9, 4'd15};
        vm = '{1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1};
        es = '{4'd11, 4'd3, 4'd1, 4'd12, 4'd2, 4'd2};
        ec = '{1'b0,  1'b1, 1'b1, 1'b0,  1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vb[i], vm[i]);
            checks++;
            if (dut_if.Sum !== es[i] || dut_if.Carry !== ec[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got sum %b carry %b expected %b/%b",
                         i, dut_if.Sum, dut_if.Carry, es[i], ec[i]);
            end
        end
        // Change inputs without an edge: output must hold.
        @(negedge clk);
        dut_if.A = 4'd0;
        dut_if.B = 4'd0;
        dut_if.m = 1'b0;
        #2;
        checks++;
        if (dut_if.Sum !== es[5] || dut_if.Carry !== ec[5]) begin
            errors++;
            $display("FAIL hold_between_edges: got sum %b carry %b expected %b/%b",
                     dut_if.Sum, dut_if.Carry, es[5], ec[5]);
        end
    endtask

    task automatic test_sweep();
        int           a_i;
        int           b_i;
        logic [W-1:0] exp_s;
        logic         exp_c;
        int           bad;
        bad = 0;
        for (int md = 0; md < 2; md++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    a_i = a;
                    b_i = b;
                    if (md == 0) begin
                        exp_s = 4'((a_i + b_i) % 16);
                        exp_c = (a_i + b_i) >= 16;
                    end else begin
                        exp_s = 4'((a_i - b_i + 16) % 16);
                        exp_c = a_i >= b_i;
                    end
                    drive(4'(a), 4'(b), md[0]);
                    checks++;
                    if (dut_if.Sum !== exp_s || dut_if.Carry !== exp_c) begin
                        errors++;
                        if (bad < 8)
                            $display("FAIL sweep a=%0d b=%0d m=%0d: got sum %b carry %b expected %b/%b",
                                     a, b, md, dut_if.Sum, dut_if.Carry, exp_s, exp_c);
                        bad++;
                    end
`ifdef ADD_SUB_OVERFLOW_EN
                    begin
                        logic       sa;
                        logic       sb;
                        logic       exp_v;
                        sa = a_i[3];
                        sb = b_i[3];
                        if (md == 0) exp_v = (sa == sb) && (exp_s[3] != sa);
                        else         exp_v = (sa != sb) && (exp_s[3] != sa);
                        checks++;
                        if (dut_if.Overflow !== exp_v) begin
                            errors++;
                            if (bad < 8)
                                $display("FAIL sweep_ovf a=%0d b=%0d m=%0d: got %b expected %b",
                                         a, b, md, dut_if.Overflow, exp_v);
                            bad++;
                        end
                    end
`endif
                end
            end
        end
    endtask

`ifdef ADD_SUB_OVERFLOW_EN
    task automatic test_overflow();
        drive(4'b0111, 4'b0001, 1'b0);
        checks++;
        if (dut_if.Sum !== 4'b1000 || dut_if.Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_add_7_1: got sum %b ovf %b expected 1000/1",
                     dut_if.Sum, dut_if.Overflow);
        end
        drive(4'b1000, 4'b0001, 1'b1);
        checks++;
        if (dut_if.Sum !== 4'b0111 || dut_if.Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sub_m8_1: got sum %b ovf %b expected 0111/1",
                     dut_if.Sum, dut_if.Overflow);
        end
        drive(4'b0011, 4'b0001, 1'b0);
        checks++;
        if (dut_if.Overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_add_3_1: got %b expected 0", dut_if.Overflow);
        end
    endtask
`endif

    task automatic test_reset_mid();
        drive(4'b1111, 4'b0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_if.Sum !== 4'b0000 || dut_if.Carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: got sum %b carry %b expected 0000/0",
                     dut_if.Sum, dut_if.Carry);
        end
`ifdef ADD_SUB_OVERFLOW_EN
        checks++;
        if (dut_if.Overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ovf: got %b expected 0", dut_if.Overflow);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0010, 4'b0001, 1'b0);
        checks++;
        if (dut_if.Sum !== 4'b0011 || dut_if.Carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_resume: got sum %b carry %b expected 0011/0",
                     dut_if.Sum, dut_if.Carry);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub_no_borrow();
        test_sub_borrow();
        test_back_to_back();
`ifdef ADD_SUB_OVERFLOW_EN
        test_overflow();
`endif
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_adder_subtractor.md
Name: four_bit_adder_subtractor

Overview:
Registered 4-bit two's-complement adder/subtractor.
- Mode input m selects the operation: A+B when m=0, A-B when m=1.
- Subtraction is computed as A + ~B + 1 on a shared ripple-carry chain.
- Sum and carry are captured in output registers on the clock edge.
- It is a leaf arithmetic block for small datapaths and ALU slices.

Parameters:
- WIDTH, 4, operand/result width in bits; the module name reflects the default, and all rules below hold for any WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- m  input  1  mode select: 0 = add, 1 = subtract.
- Sum  output  WIDTH  registered result, low WIDTH bits.
- Carry  output  1  registered carry-out of the MSB stage.

Behaviour:
- Reset: rst_n low immediately clears Sum and Carry to 0, independent of clk.
  - Release is synchronous to the next rising clk edge; the first capture happens at the first rising edge with rst_n high.
- Datapath (combinational): each B bit is XORed with m; m also drives carry-in of bit 0; WIDTH full-adder stages ripple from LSB to MSB.
- m=0: {Carry,Sum} = A + B, WIDTH+1-bit unsigned result.
- m=1: {Carry,Sum} = A + ~B + 1.
  - Sum = (A - B) mod 2^WIDTH.
  - Carry = 1 iff A >= B (unsigned), meaning no borrow.
  - Carry = 0 means a borrow; Sum then holds the two's-complement negative value.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on Sum/Carry after edge N and hold until edge N+1.
- Throughput: a new operation every cycle. There is no handshake and no enable.
- Wrap-around, all silently wrapped:
  - 15+1 -> Sum 0000, Carry 1.
  - 0-1 -> Sum 1111, Carry 0.
  - A-A -> Sum 0000, Carry 1.
- Mode change: m is sampled with the operands on the same edge. There is no dependency on the previous mode.
- Reset mid-operation: outputs clear at once. The in-flight result is discarded and not replayed.
- No X propagation from internal state; the only state is the output registers.

Optional Feature:
- Macro ADD_SUB_OVERFLOW_EN.
- When defined:
  - Adds port Overflow  output  1, registered alongside Sum.
  - Overflow = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow.
  - Reset value of Overflow is 0.
- When undefined: the Overflow port and its register do not exist; all other behaviour is identical.

Decomposition:
- Shared package add_sub_pkg holds:
  - The mode constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
  - The default width constant ADD_SUB_WIDTH = 4.
- One sub-module, full_adder (a, b, cin -> s, cout, purely combinational), instantiated WIDTH times in a generate loop.
- The top level holds the B-inversion XORs, the carry chain wiring and the output registers.

Test Plan:
- Reset: assert rst_n=0 with A=1101, B=0011 -> Sum=0000 and Carry=0 immediately, and they stay so while rst_n=0.
- Add: A=1101, B=0011, m=0, one edge -> Sum=0000, Carry=1 (13+3=16).
- Subtract without borrow: A=1111, B=0011, m=1 -> Sum=1100, Carry=1 (15-3=12). Then A=1001, B=0011, m=1 -> Sum=0110, Carry=1 (9-3=6).
- Subtract with borrow and equal operands:
  - A=0000, B=0001, m=1 -> Sum=1111, Carry=0.
  - A=0101, B=0101, m=1 -> Sum=0000, Carry=1.
- Latency and back-to-back: change operands every cycle alternating m -> each result appears exactly one edge later with no bubbles. Exhaustive 16x16x2 sweep matches the reference model.
- Overflow (ADD_SUB_OVERFLOW_EN defined):
  - A=0111, B=0001, m=0 -> Sum=1000, Overflow=1.
  - A=1000, B=0001, m=1 -> Sum=0111, Overflow=1.
  - A=0011, B=0001, m=0 -> Overflow=0.
